inst_decode_stage: RTL

INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

---
 rtl/inst_decode_stage_if.sv | 41 ++++
 rtl/inst_decode_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage_if.sv
// Decode-stage bus: upstream instruction handshake, flush, downstream
// handshake and the decoded payload.
interface inst_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_inst;
    logic [XLEN-1:0] i_pc;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_pc;
    logic [6:0]      o_instOP;
    logic [4:0]      o_instRS1;
    logic [4:0]      o_instRS2;
    logic [4:0]      o_instRD;
    logic [11:0]     o_instCSR;
    logic [XLEN-1:0] o_instIMM;
    logic            o_isIllegal;
    logic            o_isALU;
    logic            o_isECALL;
    logic            o_isEBREAK;
    logic            o_isMRET;
    logic            o_isCSR;
    logic            o_isW;

    modport master (
        output i_flush, i_valid, i_inst, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_instOP, o_instRS1, o_instRS2, o_instRD,
               o_instCSR, o_instIMM, o_isIllegal, o_isALU, o_isECALL, o_isEBREAK,
               o_isMRET, o_isCSR, o_isW
    );

    modport slave (
        input  i_flush, i_valid, i_inst, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_instOP, o_instRS1, o_instRS2, o_instRD,
               o_instCSR, o_instIMM, o_isIllegal, o_isALU, o_isECALL, o_isEBREAK,
               o_isMRET, o_isCSR, o_isW
    );
endinterface

// File: rtl/inst_decode_stage.sv
// RISC-V instruction decode stage: combinational decode at the input,
// registered into a two-entry (output + skid) buffer with valid/ready handshakes.
module inst_decode_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RV_EXT_M     = 0,
    parameter int unsigned RV_EXT_ZICSR = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    inst_decode_stage_if.slave  bus
);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [11:0]     csr;
        logic [XLEN-1:0] imm;
        logic            isIllegal;
        logic            isALU;
        logic            isECALL;
        logic            isEBREAK;
        logic            isMRET;
        logic            isCSR;
        logic            isW;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    logic [31:0]     inst;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] immI, immS, immB, immJ, immU, shamt, shamtW;
    logic            legal, alu, ecall, ebreak, mret, csrOp, wOp;
    logic [XLEN-1:0] imm;
    entry_t          dec;

    assign inst   = bus.i_inst;
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign immI   = XLEN'($signed(inst[31:20]));
    assign immS   = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign immB   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign immJ   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign immU   = XLEN'($signed({inst[31:12], 12'b0}));
    assign shamt  = IS64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    assign shamtW = XLEN'(inst[24:20]);

    always_comb begin
        legal  = 1'b0;
        alu    = 1'b0;
        ecall  = 1'b0;
        ebreak = 1'b0;
        mret   = 1'b0;
        csrOp  = 1'b0;
        wOp    = 1'b0;
        imm    = '0;
        unique case (inst[6:0])
            OP_LUI, OP_AUIPC: begin legal = 1'b1; alu = 1'b1; imm = immU; end
            OP_JAL:    begin legal = 1'b1; imm = immJ; end
            OP_JALR:   begin legal = (f3 == 3'b000); imm = immI; end
            OP_BRANCH: begin legal = (f3 != 3'b010) && (f3 != 3'b011); imm = immB; end
            OP_LOAD: begin
                legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                        (IS64 && (f3 inside {3'b011, 3'b110}));
                imm   = immI;
            end
            OP_STORE: begin
                legal = (f3 inside {3'b000, 3'b001, 3'b010}) || (IS64 && (f3 == 3'b011));
                imm   = immS;
            end
            OP_IMM: begin
                alu = 1'b1;
                // shift immediates: bit 25 is shamt[5] on RV64 and must be 0 on RV32
                if (f3 == 3'b001) begin
                    legal = (inst[31:26] == 6'b000000) && (IS64 || !inst[25]);
                    imm   = shamt;
                end else if (f3 == 3'b101) begin
                    legal = (inst[31:26] inside {6'b000000, 6'b010000}) && (IS64 || !inst[25]);
                    imm   = shamt;
                end else begin
                    legal = 1'b1;
                    imm   = immI;
                end
            end
            OP_IMM32: begin
                alu = 1'b1;
                wOp = 1'b1;
                if (f3 == 3'b000) begin
                    legal = IS64;
                    imm   = immI;
                end else begin
                    legal = IS64 && (((f3 == 3'b001) && (f7 == 7'b0000000)) ||
                                     ((f3 == 3'b101) && (f7 inside {7'b0000000, 7'b0100000})));
                    imm   = shamtW;
                end
            end
            OP_REG: begin
                alu   = 1'b1;
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && (f3 inside {3'b000, 3'b101})) ||
                        ((f7 == 7'b0000001) && (RV_EXT_M != 0));
            end
            OP_REG32: begin
                alu   = 1'b1;
                wOp   = 1'b1;
                legal = IS64 &&
                        (((f7 == 7'b0000000) && (f3 inside {3'b000, 3'b001, 3'b101})) ||
                         ((f7 == 7'b0100000) && (f3 inside {3'b000, 3'b101})) ||
                         ((f7 == 7'b0000001) && (RV_EXT_M != 0) &&
                          (f3 inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111})));
            end
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    ecall  = (inst == 32'h0000_0073);
                    ebreak = (inst == 32'h0010_0073);
                    mret   = (inst == 32'h3020_0073);
                    legal  = ecall || ebreak || mret;
                end else begin
                    csrOp = (f3 != 3'b100) && (RV_EXT_ZICSR != 0);
                    legal = csrOp;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec     = '0;
        dec.pc  = bus.i_pc;
        dec.op  = inst[6:0];
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.rd  = inst[11:7];
        dec.csr = inst[31:20];
        if (legal) begin
            dec.imm      = imm;
            dec.isALU    = alu;
            dec.isECALL  = ecall;
            dec.isEBREAK = ebreak;
            dec.isMRET   = mret;
            dec.isCSR    = csrOp;
            dec.isW      = wOp;
        end else begin
            dec.isIllegal = 1'b1;
        end
    end

    state_t state, stateNext;
    entry_t outReg, skidReg, outNext, skidNext;
    logic   readyReg;
    logic   accept, pop;

    assign accept = bus.i_valid && readyReg;
    assign pop    = (state != EMPTY) && bus.i_ready;

    always_comb begin
        stateNext = state;
        outNext   = outReg;
        skidNext  = skidReg;
        if (bus.i_flush) begin
            stateNext = EMPTY;
            outNext   = '0;
            skidNext  = '0;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin outNext = dec; stateNext = ONE; end
                ONE: begin
                    if (accept && !pop) begin
                        skidNext  = dec;
                        stateNext = TWO;
                    end else if (accept && pop) begin
                        outNext   = dec;
                    end else if (pop) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: if (pop) begin outNext = skidReg; stateNext = ONE; end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // ready mirrors "skid slot free" but stays low until the first edge out of reset
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= EMPTY;
            readyReg <= 1'b0;
            outReg   <= '0;
            skidReg  <= '0;
        end else begin
            state    <= stateNext;
            readyReg <= (stateNext != TWO);
            outReg   <= outNext;
            skidReg  <= skidNext;
        end
    end

    assign bus.o_ready     = readyReg;
    assign bus.o_valid     = (state != EMPTY);
    assign bus.o_pc        = outReg.pc;
    assign bus.o_instOP    = outReg.op;
    assign bus.o_instRS1   = outReg.rs1;
    assign bus.o_instRS2   = outReg.rs2;
    assign bus.o_instRD    = outReg.rd;
    assign bus.o_instCSR   = outReg.csr;
    assign bus.o_instIMM   = outReg.imm;
    assign bus.o_isIllegal = outReg.isIllegal;
    assign bus.o_isALU     = outReg.isALU;
    assign bus.o_isECALL   = outReg.isECALL;
    assign bus.o_isEBREAK  = outReg.isEBREAK;
    assign bus.o_isMRET    = outReg.isMRET;
    assign bus.o_isCSR     = outReg.isCSR;
    assign bus.o_isW       = outReg.isW;
endmodule
